// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the pipe_skid_reg pipeline stage.
//   state_e     : stage occupancy state (EMPTY / FULL / SKID)
//   COUNT_W     : width of the occupancy count
//   state_count : maps a state to its occupancy (0..2)
package pipe_skid_reg_pkg;

    localparam int unsigned COUNT_W = 2;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StSkid  = 2'd2
    } state_e;

    function automatic logic [COUNT_W-1:0] state_count(input state_e s);
        logic [COUNT_W-1:0] c;
        c = 2'd0;
        unique case (s)
            StEmpty: c = 2'd0;
            StFull:  c = 2'd1;
            StSkid:  c = 2'd2;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for one pipeline stage register.
//   flush_i, stall_i           : stage control (bubble / freeze)
//   in_valid_i/in_ready_o/in_data_i    : upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o : downstream handshake and payload
//   count_o                    : occupancy 0..2
// slave  : the stage itself; master : whoever drives the stage.
interface pipe_skid_reg_if
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) ();

    logic               flush_i;
    logic               stall_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [DATA_W-1:0]  in_data_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [DATA_W-1:0]  out_data_o;
    logic [COUNT_W-1:0] count_o;

    modport slave (
        input  flush_i, stall_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, count_o
    );

    modport master (
        output flush_i, stall_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, count_o
    );

endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with optional two-entry skid buffer.
//   clk_i : clock, rising edge
//   rst   : synchronous active-high reset, same effect as a flush
//   bus   : pipe_skid_reg_if slave modport (handshake, flush, stall, count)
// SKID=1: in_ready_o depends only on state and stall_i, breaking the
//         out_ready_i -> in_ready_o combinational path.
// SKID=0: single entry, in_ready_o passes out_ready_i through.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_DATA = '0,
    parameter bit                SKID     = 1'b1
) (
    input logic            clk_i,
    input logic            rst,
    pipe_skid_reg_if.slave bus
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic               valid_q, valid_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic in_ready;
    logic accept;
    logic drain;

    if (SKID) begin : g_skid_ready
        assign in_ready = (state_q != StSkid) & ~bus.stall_i;
    end else begin : g_pass_ready
        assign in_ready = ((state_q == StEmpty) | bus.out_ready_i) & ~bus.stall_i;
    end

    assign accept = bus.in_valid_i & in_ready;
    assign drain  = valid_q & bus.out_ready_i & ~bus.stall_i;

    // main_q is forced to NOP_DATA whenever the stage goes empty, so the
    // output payload can be driven straight from the register.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush_i) begin
            state_d = StEmpty;
            main_d  = NOP_DATA;
            skid_d  = NOP_DATA;
        end else if (!bus.stall_i) begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StFull;
                        main_d  = bus.in_data_i;
                    end
                end
                StFull: begin
                    if (accept && drain) begin
                        main_d = bus.in_data_i;
                    end else if (drain) begin
                        state_d = StEmpty;
                        main_d  = NOP_DATA;
                    end else if (accept && SKID) begin
                        state_d = StSkid;
                        skid_d  = bus.in_data_i;
                    end
                end
                StSkid: begin
                    if (drain) begin
                        state_d = StFull;
                        main_d  = skid_q;
                        skid_d  = NOP_DATA;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = NOP_DATA;
                    skid_d  = NOP_DATA;
                end
            endcase
        end
        valid_d = (state_d != StEmpty);
        count_d = state_count(state_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= NOP_DATA;
            skid_q  <= NOP_DATA;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = valid_q;
    assign bus.out_data_o  = main_q;
    assign bus.count_o     = count_q;

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits, at least 1.
REQ-002 Parameter NOP_DATA, default 0: payload value presented when empty, after flush and after reset.
REQ-003 Parameter SKID, default 1: 1 = two-entry skid with input-side ready independent of out_ready_i; 0 = single entry with pass-through ready.
REQ-004 Port clk_i, input, 1: sole clock, rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port flush_i, input, 1: bubble; discards all held entries.
REQ-007 Port stall_i, input, 1: freezes the stage.
REQ-008 Port in_valid_i, input, 1: upstream payload valid.
REQ-009 Port in_ready_o, output, 1: stage can accept.
REQ-010 Port in_data_i, input, DATA_W: upstream payload.
REQ-011 Port out_valid_o, output, 1: head entry valid.
REQ-012 Port out_ready_i, input, 1: downstream can take the head.
REQ-013 Port out_data_o, output, DATA_W: head payload, or NOP_DATA when empty.
REQ-014 Port count_o, output, 2: occupancy, 0..2.

Function
REQ-015 Accept condition is in_valid_i & in_ready_o; drain condition is out_valid_o & out_ready_i & !stall_i.
REQ-016 States: EMPTY (count 0), FULL (main only, count 1), SKID (main+skid, count 2); SKID state is unreachable when SKID=0.
REQ-017 SKID=1: in_ready_o = (state != SKID) & !stall_i; combinational path from stall_i only, none from out_ready_i.
REQ-018 SKID=0: in_ready_o = (state==EMPTY | out_ready_i) & !stall_i.
REQ-019 EMPTY + accept -> FULL, main <= in_data_i; latency 1 cycle input to out_valid_o.
REQ-020 FULL + accept + drain -> FULL, main <= in_data_i.
REQ-021 FULL + drain, no accept -> EMPTY.
REQ-022 FULL + accept, no drain (SKID=1) -> SKID, skid <= in_data_i, main held.
REQ-023 SKID + drain -> FULL, main <= skid; no accept possible in SKID.
REQ-024 stall_i=1 with flush_i=0: state, main, skid held; no accept, no drain; out_valid_o and out_data_o unchanged.
REQ-025 flush_i=1: next state EMPTY, payload registers <= NOP_DATA, count 0; flush_i overrides stall_i, accept and drain in the same cycle, and a coincident accepted input is dropped.
REQ-026 out_data_o = main when out_valid_o, else NOP_DATA; out_valid_o = (state != EMPTY).
REQ-027 Payload order is strictly FIFO; no entry is duplicated or lost except by flush_i or rst.

Reset
REQ-028 rst=1 at a clock edge behaves exactly as flush_i: state EMPTY, out_valid_o=0, out_data_o=NOP_DATA, count_o=0; in_ready_o=!stall_i during and after reset.
REQ-029 rst asserted mid-transfer discards all entries with no partial update; rst has priority over every other input.

Structure
REQ-030 State encoding (EMPTY/FULL/SKID) and the NOP payload constants per pipeline stage live in define.v.
REQ-031 Single module, no sub-module; stage registers (fetch/decode/execute/memory) become instances with DATA_W equal to the width of the packed stage bundle.

Verification
REQ-032 SKID=1, DATA_W=8: in_valid_i=1 with data 0x11,0x22,0x33 on consecutive cycles, out_ready_i=0 -> count_o goes 1,2,2; in_ready_o=0 on the third cycle; out_data_o=0x11.
REQ-033 Continue with out_ready_i=1 and no input -> outputs 0x11 then 0x22, count_o 1 then 0, then out_data_o=0x00.
REQ-034 Streaming with in_valid_i and out_ready_i both held at 1 -> throughput of one item per cycle, count_o stays 1, order preserved.
REQ-035 count_o=2, stall_i=1 for 3 cycles with out_ready_i=1 -> no drain; in_ready_o=0; out_data_o held.
REQ-036 count_o=2, flush_i=1 with in_valid_i=1 and data 0x44 in the same cycle -> next cycle count_o=0, out_valid_o=0, out_data_o=NOP_DATA, and 0x44 never appears at the output.
REQ-037 SKID=0: out_ready_i=0 while FULL -> in_ready_o=0; out_ready_i=1 -> in_ready_o=1 in the same cycle and the new data becomes head on the next cycle.
